route_compute_unit: RTL
=======================

ROUTE_COMPUTE_UNIT -- requirements
Module: route_compute_unit

Interface
REQ-001 SHALL have parameter NOC_WIDTH, default 4, mesh columns.
REQ-002 SHALL have parameter NOC_LENGTH, default 4, mesh rows.
REQ-003 SHALL have parameter ROUTER_ID, default 0, local node index; x = ROUTER_ID % NOC_WIDTH, y = ROUTER_ID / NOC_WIDTH.
REQ-004 SHALL have parameter NUM_PORTS, default 5, input port count.
REQ-005 SHALL have parameter ROUTE_MODE, default 0, dimension order: 0 = XY, 1 = YX.
REQ-006 SHALL use one clock and an asynchronous active-low reset, as listed below.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port flit_valid, input, [NUM_PORTS], flit present per input port.
REQ-010 SHALL have port flit_head, input, [NUM_PORTS], head flit marker.
REQ-011 SHALL have port flit_tail, input, [NUM_PORTS], tail flit marker.
REQ-012 SHALL have port dest_addr, input, [NUM_PORTS] x (X_W+Y_W), destination {y, x}, with X_W = $clog2(NOC_WIDTH) and Y_W = $clog2(NOC_LENGTH).
REQ-013 SHALL have port flit_fire, input, [NUM_PORTS], flit consumed by the switch this cycle.
REQ-014 SHALL have port route_valid, output, [NUM_PORTS], port_sel is valid and held.
REQ-015 SHALL have port port_sel, output, [NUM_PORTS] x 3, output port: 0 local, 1 north (y-1), 2 east (x+1), 3 south (y+1), 4 west (x-1).
REQ-016 SHALL have port route_err, output, [NUM_PORTS], sticky error flag.

Function
REQ-017 Each input port SHALL run an independent FSM with states IDLE and ACTIVE.
REQ-018 In IDLE with flit_valid&flit_head: compute the route, register port_sel, and go to ACTIVE; route_valid rises on the next cycle (1-cycle latency).
REQ-019 XY mode: dest x differs from local x -> east/west; otherwise dest y differs from local y -> south/north; otherwise local.
REQ-020 YX mode: resolve y first, then x.
REQ-021 In ACTIVE: route_valid=1 and port_sel SHALL stay stable until flit_fire&flit_tail; the FSM then returns to IDLE and route_valid=0 on the next cycle.
REQ-022 A single-flit packet (head&tail) SHALL behave as REQ-018 then REQ-021.
REQ-023 In ACTIVE, flit_head on a fired flit SHALL be ignored; only a tail ends the packet.
REQ-024 In IDLE, flit_fire and non-head flits SHALL be ignored; there is no state change.
REQ-025 A new head SHALL be accepted no earlier than the cycle after the tail fire; back-to-back packets give route_valid low for exactly 1 cycle.
REQ-026 Ports SHALL NOT interact; simultaneous heads on all ports are all routed in the same cycle.

Reset
REQ-027 On rst_n low, asynchronously: all FSMs IDLE, route_valid=0, port_sel=0, route_err=0.
REQ-028 Reset asserted mid-packet SHALL drop the route; after release, the next head is routed fresh.

Configuration
REQ-029 With ROUTE_ERR_CHECK_EN defined: a head whose dest x >= NOC_WIDTH or dest y >= NOC_LENGTH SHALL be routed to port 0 (local) and set route_err for that port.
REQ-030 With ROUTE_ERR_CHECK_EN defined: a non-head flit_valid in IDLE SHALL set route_err.
REQ-031 With ROUTE_ERR_CHECK_EN defined: route_err is sticky until reset.
REQ-032 Without ROUTE_ERR_CHECK_EN: route_err SHALL be tied to 0 and out-of-range destinations SHALL be routed by plain comparison.

Structure
REQ-033 Package noc_route_pkg SHALL hold the port enum (LOCAL, NORTH, EAST, SOUTH, WEST), the ROUTE_MODE constants, and the FSM state typedef.
REQ-034 Sub-module route_port_ctrl (FSM, route compute, error logic) SHALL be instantiated NUM_PORTS times in a generate loop.

Verification (4x4 mesh, ROUTER_ID=5 so local (x1,y1), addresses {y,x} 2b+2b)
REQ-035 XY mode, head dest 4'b0111 on port 0 -> next cycle route_valid[0]=1, port_sel[0]=2 (east).
REQ-036 Head dest 4'b1100: XY mode -> port_sel=4 (west); YX mode -> port_sel=3 (south).
REQ-037 Head dest 4'b0101 with head&tail and fire in the following cycle -> port_sel=0, route_valid high for 1 cycle, then 0.
REQ-038 3-flit packet to 4'b0001, body flits with different dest_addr -> port_sel stays 1 (north) until tail fire; then 1 low cycle before the next head routes.
REQ-039 rst_n pulsed low in ACTIVE -> route_valid=0 immediately without a clock; the subsequent head is routed after release.
REQ-040 ROUTE_ERR_CHECK_EN with NOC_WIDTH=3, head x=3 -> port_sel=0, route_err=1 held until reset; without the macro, route_err=0.

Source files
------------

// File: rtl/noc_route_pkg.sv
// Shared types for the mesh route-compute slice: output port encoding,
// dimension-order selectors, per-port FSM states and address width helper.
package noc_route_pkg;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  localparam int ROUTE_XY = 0;
  localparam int ROUTE_YX = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // A one-wide dimension still needs one address bit to keep ports legal.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/route_port_ctrl.sv
// Per-input-port route controller: dimension-order route compute and IDLE/ACTIVE
// packet FSM. ROUTE_ERR_CHECK_EN enables range checking and a sticky error flag.
module route_port_ctrl
  import noc_route_pkg::*;
#(
  parameter int NOC_WIDTH  = 4,
  parameter int NOC_LENGTH = 4,
  parameter int ROUTER_ID  = 0,
  parameter int ROUTE_MODE = ROUTE_XY
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic                                              valid_i,
  input  logic                                              head_i,
  input  logic                                              tail_i,
  input  logic                                              fire_i,
  input  logic [addr_w(NOC_WIDTH)+addr_w(NOC_LENGTH)-1:0]   dest_i,
  output logic                                              route_valid_o,
  output logic [2:0]                                        port_sel_o,
  output logic                                              route_err_o
);

  localparam int X_W = addr_w(NOC_WIDTH);
  localparam int Y_W = addr_w(NOC_LENGTH);
  localparam int A_W = X_W + Y_W;

  localparam logic [X_W-1:0] LOC_X = X_W'(ROUTER_ID % NOC_WIDTH);
  localparam logic [Y_W-1:0] LOC_Y = Y_W'(ROUTER_ID / NOC_WIDTH);

  logic [X_W-1:0] dst_x;
  logic [Y_W-1:0] dst_y;
  port_e          x_dir;
  port_e          y_dir;
  port_e          route;
  port_e          route_sel;
  logic           dest_oor;

  assign dst_x = dest_i[X_W-1:0];
  assign dst_y = dest_i[A_W-1:X_W];

`ifdef ROUTE_ERR_CHECK_EN
  localparam logic [X_W:0] X_LIM = (X_W+1)'(NOC_WIDTH);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(NOC_LENGTH);
  assign dest_oor = ({1'b0, dst_x} >= X_LIM) || ({1'b0, dst_y} >= Y_LIM);
`else
  assign dest_oor = 1'b0;
`endif

  always_comb begin
    x_dir = LOCAL;
    if (dst_x > LOC_X)      x_dir = EAST;
    else if (dst_x < LOC_X) x_dir = WEST;

    y_dir = LOCAL;
    if (dst_y > LOC_Y)      y_dir = SOUTH;
    else if (dst_y < LOC_Y) y_dir = NORTH;

    if (ROUTE_MODE == ROUTE_YX) route = (y_dir != LOCAL) ? y_dir : x_dir;
    else                        route = (x_dir != LOCAL) ? x_dir : y_dir;

    route_sel = dest_oor ? LOCAL : route;
  end

  state_e state_q;
  port_e  sel_q;
  logic   rv_q;
  logic   err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= LOCAL;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && head_i) begin
            state_q <= ACTIVE;
            sel_q   <= route_sel;
            rv_q    <= 1'b1;
`ifdef ROUTE_ERR_CHECK_EN
            if (dest_oor) err_q <= 1'b1;
`endif
          end
`ifdef ROUTE_ERR_CHECK_EN
          else if (valid_i) begin
            err_q <= 1'b1;
          end
`endif
        end
        ACTIVE: begin
          // Heads seen mid-packet are ignored; only a fired tail closes the route.
          if (fire_i && tail_i) begin
            state_q <= IDLE;
            rv_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign route_valid_o = rv_q;
  assign port_sel_o    = sel_q;
  assign route_err_o   = err_q;

endmodule

// File: rtl/route_compute_unit.sv
// Mesh router route-compute stage: one independent route_port_ctrl per input port.
// Optional range/protocol error checking is enabled by defining ROUTE_ERR_CHECK_EN.
module route_compute_unit
  import noc_route_pkg::*;
#(
  parameter int NOC_WIDTH  = 4,
  parameter int NOC_LENGTH = 4,
  parameter int ROUTER_ID  = 0,
  parameter int NUM_PORTS  = 5,
  parameter int ROUTE_MODE = ROUTE_XY
) (
  input  logic                                                               clk,
  input  logic                                                               rst_n,
  input  logic [NUM_PORTS-1:0]                                               flit_valid,
  input  logic [NUM_PORTS-1:0]                                               flit_head,
  input  logic [NUM_PORTS-1:0]                                               flit_tail,
  input  logic [NUM_PORTS-1:0][addr_w(NOC_WIDTH)+addr_w(NOC_LENGTH)-1:0]     dest_addr,
  input  logic [NUM_PORTS-1:0]                                               flit_fire,
  output logic [NUM_PORTS-1:0]                                               route_valid,
  output logic [NUM_PORTS-1:0][2:0]                                          port_sel,
  output logic [NUM_PORTS-1:0]                                               route_err
);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    route_port_ctrl #(
      .NOC_WIDTH  (NOC_WIDTH),
      .NOC_LENGTH (NOC_LENGTH),
      .ROUTER_ID  (ROUTER_ID),
      .ROUTE_MODE (ROUTE_MODE)
    ) u_ctrl (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .valid_i       (flit_valid[g]),
      .head_i        (flit_head[g]),
      .tail_i        (flit_tail[g]),
      .fire_i        (flit_fire[g]),
      .dest_i        (dest_addr[g]),
      .route_valid_o (route_valid[g]),
      .port_sel_o    (port_sel[g]),
      .route_err_o   (route_err[g])
    );
  end

endmodule
